// File: rtl/w0rm_core_pkg.sv
// Shared W0RM core helpers: address-width derivation used by the register file,
// the operand fetch stage and the benches.
package w0rm_core_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 8;
  localparam int DEFAULT_NUM_REGISTERS = 4;
  localparam int DEFAULT_TAG_WIDTH     = 4;

  // Ceiling log2; 0 for values <= 1.
  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // A register file always needs at least one address bit, even with one register.
  function automatic int addr_width(input int num_regs);
    int w;
    w = log2(num_regs);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/w0rm_core_operand_slot.sv
// One operand slot: registered address/data with write forwarding on capture
// and in-place update of the held operand when the register file is written.
module w0rm_core_operand_slot
  import w0rm_core_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = 2
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_capture,
  input  logic                  i_hold,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic [ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  input  logic                  i_wb_enable,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_capture_hit;
  logic                  w_hold_hit;
  logic [DATA_WIDTH-1:0] w_capture_data;

  // The register file commits the write on the same edge we sample its read port,
  // so a matching write must win over the (pre-write) read data.
  assign w_capture_hit  = i_wb_enable && (i_wb_addr == i_rd_addr);
  assign w_hold_hit     = i_wb_enable && (i_wb_addr == r_addr);
  assign w_capture_data = w_capture_hit ? i_wb_data : i_rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
      r_data <= '0;
    end else if (i_capture) begin
      r_addr <= i_rd_addr;
      r_data <= w_capture_data;
    end else if (i_hold && w_hold_hit) begin
      r_data <= i_wb_data;
    end
  end

  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/w0rm_core_operand_fetch.sv
// Register-file initiator: reads two sources and presents them in a one-entry output
// stage; one cycle latency, full throughput, in_ready = !out_valid || out_ready.
module w0rm_core_operand_fetch
  import w0rm_core_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGISTERS = DEFAULT_NUM_REGISTERS,
  parameter int TAG_WIDTH     = DEFAULT_TAG_WIDTH,
  parameter int ADDR_WIDTH    = addr_width(NUM_REGISTERS)
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd0_addr,
  input  logic [ADDR_WIDTH-1:0] in_rd1_addr,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic [ADDR_WIDTH-1:0] port_read0_addr,
  output logic [ADDR_WIDTH-1:0] port_read1_addr,
  input  logic [DATA_WIDTH-1:0] port_read0_data,
  input  logic [DATA_WIDTH-1:0] port_read1_data,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  wb_enable,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_rd0_addr,
  output logic [ADDR_WIDTH-1:0] out_rd1_addr,
  output logic [DATA_WIDTH-1:0] out_rd0_data,
  output logic [DATA_WIDTH-1:0] out_rd1_data,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  logic                 r_out_valid;
  logic [TAG_WIDTH-1:0] r_tag;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_hold;

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_hold     = r_out_valid && !out_ready;

  assign port_read0_addr = in_rd0_addr;
  assign port_read1_addr = in_rd1_addr;

  // A drain and a new accept on the same edge keep out_valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_tag       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_tag       <= in_tag;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  w0rm_core_operand_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_slot0 (
    .clk         (clk),
    .reset       (reset),
    .i_capture   (w_accept),
    .i_hold      (w_hold),
    .i_rd_addr   (in_rd0_addr),
    .i_rd_data   (port_read0_data),
    .i_wb_addr   (wb_addr),
    .i_wb_data   (wb_data),
    .i_wb_enable (wb_enable),
    .o_addr      (out_rd0_addr),
    .o_data      (out_rd0_data)
  );

  w0rm_core_operand_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_slot1 (
    .clk         (clk),
    .reset       (reset),
    .i_capture   (w_accept),
    .i_hold      (w_hold),
    .i_rd_addr   (in_rd1_addr),
    .i_rd_data   (port_read1_data),
    .i_wb_addr   (wb_addr),
    .i_wb_data   (wb_data),
    .i_wb_enable (wb_enable),
    .o_addr      (out_rd1_addr),
    .o_data      (out_rd1_data)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_tag   = r_tag;

endmodule

// File: tb/tb_w0rm_core_operand_fetch.sv
// Directed bench for the operand fetch stage with a behavioural register file
// and a scoreboard of expected bundles.
module tb_w0rm_core_operand_fetch;
  import w0rm_core_pkg::*;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int TW = 4;
  localparam int AW = addr_width(NR);

  typedef struct packed {
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [TW-1:0] tag;
  } bundle_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rd0_addr, in_rd1_addr;
  logic [TW-1:0] in_tag;
  logic [AW-1:0] port_read0_addr, port_read1_addr;
  logic [DW-1:0] port_read0_data, port_read1_data;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_enable;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_rd0_addr, out_rd1_addr;
  logic [DW-1:0] out_rd0_data, out_rd1_data;
  logic [TW-1:0] out_tag;

  logic [DW-1:0] regs [NR];
  bundle_t       exp_q [$];
  logic          m_valid;
  int            n_checks = 0;
  int            n_err    = 0;

  always #5 clk = ~clk;

  // Behavioural register file: combinational read, write committed on the clock edge.
  assign port_read0_data = regs[port_read0_addr];
  assign port_read1_data = regs[port_read1_addr];

  w0rm_core_operand_fetch #(
    .DATA_WIDTH    (DW),
    .NUM_REGISTERS (NR),
    .TAG_WIDTH     (TW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_rd0_addr     (in_rd0_addr),
    .in_rd1_addr     (in_rd1_addr),
    .in_tag          (in_tag),
    .port_read0_addr (port_read0_addr),
    .port_read1_addr (port_read1_addr),
    .port_read0_data (port_read0_data),
    .port_read1_data (port_read1_data),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .wb_enable       (wb_enable),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_rd0_addr    (out_rd0_addr),
    .out_rd1_addr    (out_rd1_addr),
    .out_rd0_data    (out_rd0_data),
    .out_rd1_data    (out_rd1_data),
    .out_tag         (out_tag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check handshake at negedge, pop on transfer, advance model, clock, commit write.
  task automatic tick();
    bundle_t       b;
    bundle_t       front;
    logic          accept;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("port_read0_addr", 32'(port_read0_addr), 32'(in_rd0_addr));
    check("port_read1_addr", 32'(port_read1_addr), 32'(in_rd1_addr));
    we = wb_enable; wa = wb_addr; wd = wb_data;
    if (reset) begin
      m_valid = 1'b0;
      exp_q.delete();
    end else begin
      accept = in_valid && (!m_valid || out_ready);
      if (m_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 32'(out_valid), 32'd0);
        end else begin
          front = exp_q.pop_front();
          check("out_rd0_addr", 32'(out_rd0_addr), 32'(front.a0));
          check("out_rd1_addr", 32'(out_rd1_addr), 32'(front.a1));
          check("out_rd0_data", 32'(out_rd0_data), 32'(front.d0));
          check("out_rd1_data", 32'(out_rd1_data), 32'(front.d1));
          check("out_tag", 32'(out_tag), 32'(front.tag));
        end
        m_valid = 1'b0;
      end else if (m_valid && we && exp_q.size() > 0) begin
        front = exp_q[0];
        if (front.a0 == wa) front.d0 = wd;
        if (front.a1 == wa) front.d1 = wd;
        exp_q[0] = front;
      end
      if (accept) begin
        b.a0  = in_rd0_addr;
        b.a1  = in_rd1_addr;
        b.d0  = (we && wa == in_rd0_addr) ? wd : regs[in_rd0_addr];
        b.d1  = (we && wa == in_rd1_addr) ? wd : regs[in_rd1_addr];
        b.tag = in_tag;
        exp_q.push_back(b);
        m_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (we) regs[wa] = wd;
  endtask

  task automatic request(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [TW-1:0] t);
    in_valid    = 1'b1;
    in_rd0_addr = a0;
    in_rd1_addr = a1;
    in_tag      = t;
  endtask

  task automatic write(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_enable = en;
    wb_addr   = a;
    wb_data   = d;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_rd0_addr"}, 32'(out_rd0_addr), 32'd0);
    check({tag, "_rd1_addr"}, 32'(out_rd1_addr), 32'd0);
    check({tag, "_rd0_data"}, 32'(out_rd0_data), 32'd0);
    check({tag, "_rd1_data"}, 32'(out_rd1_data), 32'd0);
    check({tag, "_tag"}, 32'(out_tag), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    regs[0] = 8'h10; regs[1] = 8'h21; regs[2] = 8'h32; regs[3] = 8'h43;
    m_valid = 1'b0;
    reset = 1'b1; out_ready = 1'b0;
    in_valid = 1'b0; in_rd0_addr = '0; in_rd1_addr = '0; in_tag = '0;
    write(1'b0, '0, '0);
    #1;
    tick();
    tick();
    reset = 1'b0;
    check_cleared("reset");

    // Basic read with tag passthrough.
    request(2'd1, 2'd3, 4'd5); out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_rd0", 32'(out_rd0_data), 32'h21);
    check("basic_rd1", 32'(out_rd1_data), 32'h43);
    check("basic_tag", 32'(out_tag), 32'd5);
    tick();
    check("basic_drained", 32'(out_valid), 32'd0);

    // Same register on both ports with a same-cycle write.
    request(2'd2, 2'd2, 4'd6); write(1'b1, 2'd2, 8'hAA);
    tick();
    in_valid = 1'b0; write(1'b0, '0, '0);
    check("fwd_rd0", 32'(out_rd0_data), 32'hAA);
    check("fwd_rd1", 32'(out_rd1_data), 32'hAA);
    tick();

    // Held bundle updated by a later write; a second request waits behind it.
    request(2'd0, 2'd1, 4'd7); out_ready = 1'b0;
    tick();
    request(2'd3, 2'd3, 4'd9);
    tick();
    write(1'b1, 2'd1, 8'h5C);
    tick();
    write(1'b0, '0, '0);
    tick();
    check("hold_rd0", 32'(out_rd0_data), 32'h10);
    check("hold_rd1", 32'(out_rd1_data), 32'h5C);
    check("hold_tag", 32'(out_tag), 32'd7);
    out_ready = 1'b1;
    tick();
    check("swap_tag", 32'(out_tag), 32'd9);

    // Back-to-back requests with no bubbles.
    request(2'd0, 2'd1, 4'd1); tick();
    request(2'd2, 2'd3, 4'd2); tick();
    check("b2b_valid", 32'(out_valid), 32'd1);
    request(2'd1, 2'd0, 4'd3); tick();
    check("b2b_valid_last", 32'(out_valid), 32'd1);
    check("b2b_rd0", 32'(out_rd0_data), 32'h5C);
    check("b2b_rd1", 32'(out_rd1_data), 32'h10);
    in_valid = 1'b0;
    tick();

    // Reset while a bundle is held and another request is offered.
    request(2'd3, 2'd0, 4'hF); out_ready = 1'b0;
    tick();
    check("prereset_valid", 32'(out_valid), 32'd1);
    request(2'd1, 2'd1, 4'hE); reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check_cleared("midreset");
    tick();
    check("post_reset_idle", 32'(out_valid), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/w0rm_core_operand_fetch.md
# w0rm_core_operand_fetch

Register-file initiator for the W0RM core: accepts an issue request naming two source registers, drives the two read ports of `W0RM_Core_RegisterFile` (SINGLE_CYCLE=1, combinational read), and presents both operands downstream in a one-entry registered output stage with valid/ready handshake. It snoops the register-file write port so that operands are never stale: a same-cycle write is forwarded on capture, and a write that lands while an entry is held updates the held operand.

## Interface
- `DATA_WIDTH`, 8, operand/register width
- `NUM_REGISTERS`, 4, register count; `ADDR_WIDTH` = ceil(log2(NUM_REGISTERS)), minimum 1
- `TAG_WIDTH`, 4, opaque payload carried alongside the operands

- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  issue request present
- `in_ready`  out  1  request accepted when `in_valid && in_ready`
- `in_rd0_addr`, `in_rd1_addr`  in  ADDR_WIDTH  source registers
- `in_tag`  in  TAG_WIDTH  passthrough payload
- `port_read0_addr`, `port_read1_addr`  out  ADDR_WIDTH  to register-file read ports
- `port_read0_data`, `port_read1_data`  in  DATA_WIDTH  from register-file read ports (same-cycle)
- `wb_addr`  in  ADDR_WIDTH  register-file write address (snooped, same net as `port_write_addr`)
- `wb_data`  in  DATA_WIDTH  register-file write data
- `wb_enable`  in  1  register-file write enable
- `out_valid`  out  1  operand bundle present
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`
- `out_rd0_addr`, `out_rd1_addr`  out  ADDR_WIDTH  registered source addresses
- `out_rd0_data`, `out_rd1_data`  out  DATA_WIDTH  registered operands
- `out_tag`  out  TAG_WIDTH  registered payload

## Operation
- `port_readN_addr` = `in_rdN_addr` combinationally, every cycle.
- `in_ready` = `!out_valid || out_ready` (combinational; no dependence on `in_valid`).
- Capture (accept cycle): `out_rdN_data` <= (`wb_enable && wb_addr == in_rdN_addr`) ? `wb_data` : `port_readN_data`; addresses and tag registered; `out_valid` <= 1.
- Hold (`out_valid && !out_ready`): if `wb_enable && wb_addr == out_rdN_addr`, `out_rdN_data` <= `wb_data`; otherwise unchanged. Addresses/tag never change while held.
- Drain without new accept: `out_valid` <= 0; data registers keep last value.
- Simultaneous drain and accept: new bundle replaces old in the same edge, `out_valid` stays 1 (full throughput, one bundle per cycle).
- `in_rd0_addr == in_rd1_addr`: both slots capture identical data, both forwarded.
- Address out of range (>= NUM_REGISTERS): passed through; data is whatever the register file returns.

## Timing
- Reset values: `out_valid` 0, `out_rd0_addr` 0, `out_rd1_addr` 0, `out_rd0_data` 0, `out_rd1_data` 0, `out_tag` 0; `in_ready` therefore 1 during and after reset.
- Reset mid-operation: held bundle discarded, no downstream transfer; request presented in the reset cycle is not accepted.
- Latency: accept at edge N -> `out_valid` high after edge N, visible cycle N+1.
- Write at edge N with `wb_addr` matching captured address: captured value equals `wb_data` (forwarded), never the pre-write value.
- `out_valid` only falls on a drain with no accept, or reset.

## Structure
- Shared package `w0rm_core_pkg`: `log2` function and derived `ADDR_WIDTH` rule, reused by the register file and benches.
- One sub-module, `w0rm_core_operand_slot`, instantiated twice: address/data register with capture-forward mux and hold-update compare. Top level owns handshake, `out_valid`, tag.

## Test plan
- Reset, regs preloaded R0..R3 = 0x10,0x21,0x32,0x43; request (1,3,tag 5), `out_ready`=1 -> next cycle `out_valid`=1, data 0x21/0x43, tag 5.
- Request (2,2) with write R2=0xAA same cycle -> both operands 0xAA.
- Request (0,1), `out_ready`=0 for 3 cycles, write R1=0x5C on cycle 2 -> held `out_rd1_data` becomes 0x5C, `out_rd0_data` stays 0x10, `in_ready`=0 throughout.
- Back-to-back requests (0,1),(2,3),(1,0) with `out_ready`=1 -> three consecutive valid bundles, no bubbles.
- Assert `reset` while bundle held -> next cycle `out_valid`=0, all data/address outputs 0, `in_ready`=1.
